instr_fetch: RTL and testbench



---
 rtl/proc_defs.sv | 23 ++
 rtl/pc_unit.sv | 39 +++
 rtl/instr_fetch.sv | 95 +++++++++
 tb/tb_instr_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_defs.sv
// Shared fetch-side definitions: word width,
// reset PC default, FSM and next-PC encodings.
package proc_defs;

  localparam int unsigned XLEN = 16;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_VALID = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_BR   = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/pc_unit.sv
// Program counter register with hold / +1 /
// branch-target next-PC mux and link value.
module pc_unit
  import proc_defs::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  input  pc_sel_e pc_sel,
  input  word_t   br_tgt,
  output word_t   pc,
  output word_t   pc_plus1
);

  word_t pc_q;
  word_t pc_d;

  assign pc       = pc_q;
  assign pc_plus1 = pc_q + 16'd1;

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PC_INC:  pc_d = pc_plus1;
      PC_BR:   pc_d = br_tgt;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC ownership, memory request,
// instruction register and decode handshake.
module instr_fetch
  import proc_defs::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] im_addr,
  output logic        im_rd,
  input  logic [15:0] im_rdata,
  input  logic        im_rdy,
  output logic [15:0] instr,
  output logic        instr_vld,
  input  logic        instr_acc,
  input  logic        br_taken,
  input  logic [15:0] br_tgt,
  input  logic        hlt,
  output logic [15:0] pc_plus1,
  output logic        halted
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  pc_sel_e      pc_sel;
  logic         cap;
  word_t        pc;
  word_t        instr_q;

  pc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_sel   (pc_sel),
    .br_tgt   (br_tgt),
    .pc       (pc),
    .pc_plus1 (pc_plus1)
  );

  // rst_n gates the request so it drops without waiting for a clock
  assign im_rd     = rst_n & (state_q == ST_FETCH);
  assign im_addr   = pc;
  assign instr     = instr_q;
  assign instr_vld = (state_q == ST_VALID);
  assign halted    = (state_q == ST_HALT);

  always_comb begin
    state_d = state_q;
    pc_sel  = PC_HOLD;
    cap     = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (im_rdy) begin
          cap     = 1'b1;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        // halt outranks a simultaneous redirect
        if (instr_acc) begin
          if (hlt) begin
            state_d = ST_HALT;
          end else if (br_taken) begin
            pc_sel  = PC_BR;
            state_d = ST_FETCH;
          end else begin
            pc_sel  = PC_INC;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (cap) begin
        instr_q <= im_rdata;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with
// hand-computed expected values.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [15:0] im_addr;
  logic        im_rd;
  logic [15:0] im_rdata;
  logic        im_rdy;
  logic [15:0] instr;
  logic        instr_vld;
  logic        instr_acc;
  logic        br_taken;
  logic [15:0] br_tgt;
  logic        hlt;
  logic [15:0] pc_plus1;
  logic        halted;

  int total;
  int bad;

  instr_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .im_addr   (im_addr),
    .im_rd     (im_rd),
    .im_rdata  (im_rdata),
    .im_rdy    (im_rdy),
    .instr     (instr),
    .instr_vld (instr_vld),
    .instr_acc (instr_acc),
    .br_taken  (br_taken),
    .br_tgt    (br_tgt),
    .hlt       (hlt),
    .pc_plus1  (pc_plus1),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag,
                           input logic [15:0] a);
    chk({tag, "_rd"}, {15'd0, im_rd}, 16'd1);
    chk({tag, "_addr"}, im_addr, a);
    chk({tag, "_vld"}, {15'd0, instr_vld}, 16'd0);
  endtask

  task automatic chk_valid(input string tag,
                           input logic [15:0] w,
                           input logic [15:0] p1);
    chk({tag, "_vld"}, {15'd0, instr_vld}, 16'd1);
    chk({tag, "_rd"}, {15'd0, im_rd}, 16'd0);
    chk({tag, "_instr"}, instr, w);
    chk({tag, "_pc1"}, pc_plus1, p1);
  endtask

  task automatic chk_halt(input string tag,
                          input logic [15:0] a);
    chk({tag, "_hlt"}, {15'd0, halted}, 16'd1);
    chk({tag, "_rd"}, {15'd0, im_rd}, 16'd0);
    chk({tag, "_vld"}, {15'd0, instr_vld}, 16'd0);
    chk({tag, "_addr"}, im_addr, a);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    im_rdata  = 16'h0000;
    im_rdy    = 1'b0;
    instr_acc = 1'b0;
    br_taken  = 1'b0;
    br_tgt    = 16'h0000;
    hlt       = 1'b0;

    #3;
    chk("rst_rd", {15'd0, im_rd}, 16'd0);
    chk("rst_vld", {15'd0, instr_vld}, 16'd0);
    chk("rst_hlt", {15'd0, halted}, 16'd0);
    chk("rst_instr", instr, 16'h0000);
    step();
    rst_n = 1'b1;
    #1;
    chk_fetch("rel", 16'h0000);

    // zero-wait memory, decode always accepting
    im_rdy    = 1'b1;
    im_rdata  = 16'h1234;
    instr_acc = 1'b1;
    step();
    chk_valid("zw0", 16'h1234, 16'h0001);
    step();
    chk_fetch("zw1", 16'h0001);
    step();
    chk_valid("zw1v", 16'h1234, 16'h0002);
    step();
    chk_fetch("zw2", 16'h0002);

    // three wait cycles before the response
    im_rdy    = 1'b0;
    instr_acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_fetch("wait", 16'h0002);
    end
    im_rdy   = 1'b1;
    im_rdata = 16'hABCD;
    step();
    chk_valid("wresp", 16'hABCD, 16'h0003);

    // stall with ignored redirect and ignored im_rdy
    im_rdata = 16'hFFFF;
    br_taken = 1'b1;
    br_tgt   = 16'h0040;
    hlt      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_valid("stall", 16'hABCD, 16'h0003);
    end
    hlt = 1'b0;

    // redirect to 5
    im_rdy    = 1'b0;
    instr_acc = 1'b1;
    br_tgt    = 16'h0005;
    step();
    chk_fetch("br5", 16'h0005);
    instr_acc = 1'b0;
    br_taken  = 1'b0;
    im_rdy    = 1'b1;
    im_rdata  = 16'h1111;
    step();
    chk_valid("at5", 16'h1111, 16'h0006);

    // redirect from 5 to 0x40
    im_rdy    = 1'b0;
    instr_acc = 1'b1;
    br_taken  = 1'b1;
    br_tgt    = 16'h0040;
    step();
    chk_fetch("br40", 16'h0040);

    // get to 0xFFFF and wrap
    instr_acc = 1'b0;
    br_taken  = 1'b0;
    im_rdy    = 1'b1;
    im_rdata  = 16'h5555;
    step();
    chk_valid("at40", 16'h5555, 16'h0041);
    im_rdy    = 1'b0;
    instr_acc = 1'b1;
    br_taken  = 1'b1;
    br_tgt    = 16'hFFFF;
    step();
    chk_fetch("brff", 16'hFFFF);
    instr_acc = 1'b0;
    br_taken  = 1'b0;
    im_rdy    = 1'b1;
    im_rdata  = 16'h2222;
    step();
    chk_valid("atff", 16'h2222, 16'h0000);
    im_rdy    = 1'b0;
    instr_acc = 1'b1;
    step();
    chk_fetch("wrap", 16'h0000);
    instr_acc = 1'b0;
    im_rdy    = 1'b1;
    im_rdata  = 16'h3333;
    step();
    chk_valid("at0", 16'h3333, 16'h0001);
    im_rdy    = 1'b0;
    instr_acc = 1'b1;
    step();
    chk_fetch("to1", 16'h0001);
    instr_acc = 1'b0;
    im_rdy    = 1'b1;
    im_rdata  = 16'h7000;
    step();
    chk_valid("at1", 16'h7000, 16'h0002);

    // halt and branch together: halt wins
    im_rdy    = 1'b0;
    instr_acc = 1'b1;
    hlt       = 1'b1;
    br_taken  = 1'b1;
    br_tgt    = 16'h0077;
    step();
    chk_halt("halt", 16'h0001);
    hlt      = 1'b0;
    br_taken = 1'b0;
    im_rdy   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_halt("hold", 16'h0001);
    end

    // reset out of halt
    im_rdy    = 1'b0;
    instr_acc = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("hrst_hlt", {15'd0, halted}, 16'd0);
    chk("hrst_rd", {15'd0, im_rd}, 16'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk_fetch("hrel", 16'h0000);

    // move to a nonzero PC, then reset mid-wait
    im_rdy    = 1'b1;
    im_rdata  = 16'h4444;
    instr_acc = 1'b1;
    step();
    step();
    chk_fetch("pre", 16'h0001);
    im_rdy    = 1'b0;
    instr_acc = 1'b0;
    step();
    chk_fetch("mwait", 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("mrst_rd", {15'd0, im_rd}, 16'd0);
    chk("mrst_addr", im_addr, 16'h0000);
    #1;
    rst_n = 1'b1;
    #1;
    chk_fetch("mrel", 16'h0000);
    chk("mrel_hlt", {15'd0, halted}, 16'd0);
    im_rdy   = 1'b1;
    im_rdata = 16'h9999;
    step();
    chk_valid("mresp", 16'h9999, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
